// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the TinyTapeout 8N1 UART receiver.
package uart_rx_pkg;
  localparam int DATA_W         = 8;
  localparam int STATUS_W       = 4;
  localparam int VALID_BIT      = 0;
  localparam int FRAME_ERR_BIT  = 1;
  localparam int OVERRUN_BIT    = 2;
  localparam int PARITY_ERR_BIT = 3;
  localparam logic [7:0] UIO_OE_VALUE = 8'h0F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: synchronized line/ack in, byte and status flags out.
interface uart_rx_if;
  import uart_rx_pkg::*;
  logic                rx;
  logic                ack;
  logic [DATA_W-1:0]   data;
  logic [STATUS_W-1:0] status;

  modport master (output rx, ack, input data, status);
  modport slave  (input rx, ack, output data, status);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_core.sv
// UART receive FSM with sticky status flags. Build with UART_RX_PARITY_EN
// defined to add one even-parity bit after the data bits.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e         state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [DATA_W-1:0] sh, data_q;
  logic              valid_q, ferr_q, ovr_q, perr_q, par_bad;

  wire tick = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      // Clear first so any flag set later in this cycle takes priority.
      if (bus.ack) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
        perr_q  <= 1'b0;
      end
      cnt <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!bus.rx) state <= S_START;
        end
        S_START: if (cnt == CNT_HALF) begin
          cnt     <= '0;
          bit_idx <= '0;
          par_bad <= 1'b0;
          state   <= bus.rx ? S_IDLE : S_DATA;
        end
        S_DATA: if (tick) begin
          cnt     <= '0;
          sh      <= {bus.rx, sh[DATA_W-1:1]};
          bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= S_PARITY;
`else
          if (bit_idx == 3'd7) state <= S_STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (tick) begin
          cnt <= '0;
          if (bus.rx != ^sh) begin
            par_bad <= 1'b1;
            perr_q  <= 1'b1;
          end
          state <= S_STOP;
        end
`endif
        S_STOP: if (tick) begin
          cnt <= '0;
          if (bus.rx) begin
            if (!par_bad) begin
              data_q  <= sh;
              valid_q <= 1'b1;
              if (valid_q && !bus.ack) ovr_q <= 1'b1;
            end
            state <= S_IDLE;
          end else begin
            ferr_q <= 1'b1;
            state  <= S_BREAK;
          end
        end
        // Held-low line must return high before another start is accepted.
        S_BREAK: begin
          cnt <= '0;
          if (bus.rx) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.status                 = '0;
    bus.status[VALID_BIT]      = valid_q;
    bus.status[FRAME_ERR_BIT]  = ferr_q;
    bus.status[OVERRUN_BIT]    = ovr_q;
    bus.status[PARITY_ERR_BIT] = perr_q;
  end

  assign bus.data = data_q;
endmodule

// File: rtl/tt_um_murra232_uart_rx.sv
// TinyTapeout wrapper: synchronizes rx/ack pins and exposes byte and flags.
// UART_RX_PARITY_EN enables the even-parity variant.
module tt_um_murra232_uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  uart_rx_if bus ();

  logic rx_s, ack_s;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk(clk), .rst_n(rst_n), .d(ui_in[0]), .q(rx_s)
  );
  sync_2ff #(.RST_VAL(1'b0)) u_ack_sync (
    .clk(clk), .rst_n(rst_n), .d(ui_in[1]), .q(ack_s)
  );

  assign bus.rx  = rx_s;
  assign bus.ack = ack_s;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  assign uo_out  = bus.data;
  assign uio_out = {4'b0, bus.status};
  assign uio_oe  = UIO_OE_VALUE;

  wire unused_pins = &{1'b0, ena, uio_in, ui_in[7:2]};
endmodule

// File: tb/tb_tt_um_murra232_uart_rx.sv
// Directed bench for the UART receiver at 16 clocks per bit.
module tb_tt_um_murra232_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in, uo_out, uio_out, uio_oe;
  int         errors = 0;
  int         checks = 0;

  uart_rx_if bus ();

  assign ui_in = {6'b0, bus.ack, bus.rx};

  tt_um_murra232_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .ena(1'b1), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(8'h00), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = par;
    repeat (CPB) @(negedge clk);
`else
    if (par === 1'bz) bus.rx = 1'b1;
`endif
    bus.rx = stop;
    repeat (CPB) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  task automatic pulse_ack();
    bus.ack = 1'b1;
    repeat (3) @(negedge clk);
    bus.ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.rx  = 1'b1;
    bus.ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_uo_out", uo_out, 8'h00);
    chk("rst_uio_out", uio_out, 8'h00);
    chk("rst_uio_oe", uio_oe, 8'h0F);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single byte then ack
    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_data", uo_out, 8'hA5);
    chk("a5_flags", uio_out, 8'h01);
    pulse_ack();
    chk("a5_ack_flags", uio_out, 8'h00);
    chk("a5_ack_data", uo_out, 8'hA5);

    // back-to-back frames without ack
    send_frame(8'h3C, 1'b1, 1'b0);
    chk("b2b_first", uo_out, 8'h3C);
    send_frame(8'hC3, 1'b1, 1'b0);
    chk("ovr_data", uo_out, 8'hC3);
    chk("ovr_flags", uio_out, 8'h05);
    pulse_ack();
    chk("ovr_ack_flags", uio_out, 8'h00);
    chk("ovr_ack_data", uo_out, 8'hC3);

    // frame error followed by a held-low line
    send_frame(8'h55, 1'b0, 1'b0);
    bus.rx = 1'b0;
    chk("ferr_flags", uio_out, 8'h02);
    chk("ferr_data", uo_out, 8'hC3);
    repeat (40) @(negedge clk);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("break_flags", uio_out, 8'h02);
    chk("break_data", uo_out, 8'hC3);
    pulse_ack();
    chk("ferr_ack", uio_out, 8'h00);

    // 4-cycle glitch is rejected
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_flags", uio_out, 8'h00);
    chk("glitch_data", uo_out, 8'hC3);

    // reset after four data bits of 7E
    bus.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (i == 0) ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge clk);
    end
    rst_n  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_uo_out", uo_out, 8'h00);
    chk("midrst_uio_out", uio_out, 8'h00);
    chk("midrst_uio_oe", uio_oe, 8'h0F);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b1, 1'b0);
    chk("after_rst_data", uo_out, 8'h7E);
    chk("after_rst_flags", uio_out, 8'h01);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h01, 1'b1, 1'b1);
    chk("par_ok_data", uo_out, 8'h01);
    chk("par_ok_flags", uio_out, 8'h01);
    pulse_ack();
    send_frame(8'h03, 1'b1, 1'b1);
    chk("par_bad_flags", uio_out, 8'h08);
    chk("par_bad_data", uo_out, 8'h01);
    pulse_ack();
    chk("par_ack", uio_out, 8'h00);
`endif

    chk("end_uio_oe", uio_oe, 8'h0F);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
